// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl
//
// Sequences single ALU operations between a valid/ready request port and a
// valid/ready response port. A request is latched in IDLE. One EXEC cycle lets
// the external ALU sample the operands. One CAPT cycle waits for the ALU
// result, which is captured at the end of CAPT. The response is then held in
// RESP until the consumer takes it.
//
// Timing: accept at edge N, RspValid_o seen high at edge N+3, next accept no
// earlier than edge N+4.
//
// Optional feature:
//   ALU_CTRL_OVF_CNT_EN  When defined, OvfCount_o counts response handshakes
//                        that carry RspOverFlow_o=1, saturating at 255. When
//                        undefined, the counter is omitted and OvfCount_o is 0.
//
// Ports:
//   Clk_i          clock, all state on the rising edge
//   Reset_i        asynchronous active-high reset
//   ReqValid_i     request valid
//   ReqReady_o     request ready, high only in IDLE
//   ReqOpc_i       request opcode (0 ADD, 1 SUB, 2 AND, 3 OR)
//   ReqA_i         request operand A
//   ReqB_i         request operand B
//   AluOpc_o       opcode to the ALU, from the operand registers
//   AluA_o         operand A to the ALU, from the operand registers
//   AluB_o         operand B to the ALU, from the operand registers
//   AluDout_i      ALU result, valid one cycle after the operands are sampled
//   AluOverFlow_i  ALU overflow flag, same timing as AluDout_i
//   RspValid_o     response valid, high only in RESP
//   RspReady_i     response ready
//   RspData_o      captured ALU result
//   RspOverFlow_o  captured ALU overflow flag
//   OpCount_o      completed-response counter, wraps at 16 bits
//   OvfCount_o     overflow-response counter (see ALU_CTRL_OVF_CNT_EN)
// -----------------------------------------------------------------------------
module alu_ctrl #(
    parameter int Width = 8
) (
    input  logic             Clk_i,
    input  logic             Reset_i,
    input  logic             ReqValid_i,
    output logic             ReqReady_o,
    input  logic [1:0]       ReqOpc_i,
    input  logic [Width-1:0] ReqA_i,
    input  logic [Width-1:0] ReqB_i,
    output logic [1:0]       AluOpc_o,
    output logic [Width-1:0] AluA_o,
    output logic [Width-1:0] AluB_o,
    input  logic [Width-1:0] AluDout_i,
    input  logic             AluOverFlow_i,
    output logic             RspValid_o,
    input  logic             RspReady_i,
    output logic [Width-1:0] RspData_o,
    output logic             RspOverFlow_o,
    output logic [15:0]      OpCount_o,
    output logic [7:0]       OvfCount_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         opc_q;
    logic [Width-1:0]   a_q, b_q;
    logic [Width-1:0]   rsp_data_q;
    logic               rsp_ovf_q;
    logic [15:0]        op_count_q;
    logic               accept;
    logic               rsp_hs;
    logic               capture;

    // Next-state and handshake decode.
    // NOTE: every always_comb output gets a default before the case statement;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        rsp_hs  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ReqValid_i) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = CAPT;
            CAPT: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (RspReady_i) begin
                    rsp_hs  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and datapath registers. The asynchronous reset drops an
    // in-flight operation on the spot, so no response is ever produced for it.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q    <= IDLE;
            opc_q      <= 2'd0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            rsp_ovf_q  <= 1'b0;
            op_count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opc_q <= ReqOpc_i;
                a_q   <= ReqA_i;
                b_q   <= ReqB_i;
            end
            if (capture) begin
                rsp_data_q <= AluDout_i;
                rsp_ovf_q  <= AluOverFlow_i;
            end
            // Natural 16-bit rollover gives the 0xFFFF -> 0x0000 wrap.
            if (rsp_hs) begin
                op_count_q <= op_count_q + 16'd1;
            end
        end
    end

`ifdef ALU_CTRL_OVF_CNT_EN
    logic [7:0] ovf_count_q;

    // Counts only responses that actually leave with the overflow flag set,
    // holding at 255 rather than wrapping.
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            ovf_count_q <= 8'd0;
        end else if (rsp_hs && rsp_ovf_q && (ovf_count_q != 8'hFF)) begin
            ovf_count_q <= ovf_count_q + 8'd1;
        end
    end

    assign OvfCount_o = ovf_count_q;
`else
    assign OvfCount_o = 8'd0;
`endif

    assign ReqReady_o    = (state_q == IDLE);
    assign RspValid_o    = (state_q == RESP);
    assign AluOpc_o      = opc_q;
    assign AluA_o        = a_q;
    assign AluB_o        = b_q;
    assign RspData_o     = rsp_data_q;
    assign RspOverFlow_o = rsp_ovf_q;
    assign OpCount_o     = op_count_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl
//
// Directed bench for alu_ctrl with Width=8. A small registered ALU model
// answers the controller one cycle after it samples the operands. ADD reports
// carry-out as overflow, SUB reports borrow, AND/OR never overflow. Outputs
// are sampled on the falling edge and inputs are driven there as well.
// -----------------------------------------------------------------------------
module tb_alu_ctrl;

    localparam int W = 8;

    logic         Clk_i = 1'b0;
    logic         Reset_i;
    logic         ReqValid_i;
    logic         ReqReady_o;
    logic [1:0]   ReqOpc_i;
    logic [W-1:0] ReqA_i, ReqB_i;
    logic [1:0]   AluOpc_o;
    logic [W-1:0] AluA_o, AluB_o;
    logic [W-1:0] AluDout_i;
    logic         AluOverFlow_i;
    logic         RspValid_o;
    logic         RspReady_i;
    logic [W-1:0] RspData_o;
    logic         RspOverFlow_o;
    logic [15:0]  OpCount_o;
    logic [7:0]   OvfCount_o;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    alu_ctrl #(.Width(W)) dut (
        .Clk_i         (Clk_i),
        .Reset_i       (Reset_i),
        .ReqValid_i    (ReqValid_i),
        .ReqReady_o    (ReqReady_o),
        .ReqOpc_i      (ReqOpc_i),
        .ReqA_i        (ReqA_i),
        .ReqB_i        (ReqB_i),
        .AluOpc_o      (AluOpc_o),
        .AluA_o        (AluA_o),
        .AluB_o        (AluB_o),
        .AluDout_i     (AluDout_i),
        .AluOverFlow_i (AluOverFlow_i),
        .RspValid_o    (RspValid_o),
        .RspReady_i    (RspReady_i),
        .RspData_o     (RspData_o),
        .RspOverFlow_o (RspOverFlow_o),
        .OpCount_o     (OpCount_o),
        .OvfCount_o    (OvfCount_o)
    );

    always #5 Clk_i = ~Clk_i;

    always @(posedge Clk_i) cyc <= cyc + 1;

    // Registered ALU model: result appears one cycle after sampling.
    always @(posedge Clk_i) begin
        case (AluOpc_o)
            2'd0: {AluOverFlow_i, AluDout_i} <= {1'b0, AluA_o} + {1'b0, AluB_o};
            2'd1: {AluOverFlow_i, AluDout_i} <= {1'b0, AluA_o} - {1'b0, AluB_o};
            2'd2: {AluOverFlow_i, AluDout_i} <= {1'b0, AluA_o & AluB_o};
            default: {AluOverFlow_i, AluDout_i} <= {1'b0, AluA_o | AluB_o};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Issue one request with RspReady_i=1 and return the captured response.
    // acc_cyc is the number of the edge that accepted the request.
    task automatic run_op(input logic [1:0] opc, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] d, output logic o, output int acc_cyc);
        int n;
        @(negedge Clk_i);
        ReqOpc_i   = opc;
        ReqA_i     = a;
        ReqB_i     = b;
        ReqValid_i = 1'b1;
        RspReady_i = 1'b1;
        n = 0;
        while (!ReqReady_o && n < 10) begin
            @(negedge Clk_i);
            n++;
        end
        check("accept_ready", ReqReady_o, 1);
        acc_cyc = cyc + 1;
        @(negedge Clk_i);
        ReqValid_i = 1'b0;
        n = 0;
        while (!RspValid_o && n < 10) begin
            @(negedge Clk_i);
            n++;
        end
        check("rsp_valid_seen", RspValid_o, 1);
        d = RspData_o;
        o = RspOverFlow_o;
        @(posedge Clk_i);
    endtask

    initial begin
        logic [7:0] d1, d2;
        logic       o1, o2;
        int         acc1, acc2;
        int         n;

        Reset_i       = 1'b1;
        ReqValid_i    = 1'b0;
        ReqOpc_i      = 2'd0;
        ReqA_i        = '0;
        ReqB_i        = '0;
        RspReady_i    = 1'b0;
        repeat (3) @(posedge Clk_i);
        @(negedge Clk_i);
        Reset_i = 1'b0;
        @(negedge Clk_i);

        // Reset state.
        check("rst_req_ready", ReqReady_o, 1);
        check("rst_rsp_valid", RspValid_o, 0);
        check("rst_alu_opc",   AluOpc_o, 0);
        check("rst_alu_a",     AluA_o, 0);
        check("rst_alu_b",     AluB_o, 0);
        check("rst_rsp_data",  RspData_o, 0);
        check("rst_rsp_ovf",   RspOverFlow_o, 0);
        check("rst_op_count",  OpCount_o, 0);
        check("rst_ovf_count", OvfCount_o, 0);

        // ADD 200+100 with exact cycle-by-cycle latency.
        ReqValid_i = 1'b1;
        ReqOpc_i   = 2'd0;
        ReqA_i     = 8'd200;
        ReqB_i     = 8'd100;
        RspReady_i = 1'b1;
        @(posedge Clk_i);               // edge N: accept
        @(negedge Clk_i);
        ReqValid_i = 1'b0;
        check("add_n_ready",   ReqReady_o, 0);
        check("add_n_valid",   RspValid_o, 0);
        check("add_alu_a",     AluA_o, 200);
        check("add_alu_b",     AluB_o, 100);
        check("add_alu_opc",   AluOpc_o, 0);
        @(negedge Clk_i);               // after edge N+1
        check("add_n1_valid",  RspValid_o, 0);
        @(negedge Clk_i);               // after edge N+2, before edge N+3
        check("add_n3_valid",  RspValid_o, 1);
        check("add_data",      RspData_o, 44);
        check("add_ovf",       RspOverFlow_o, 1);
        check("add_cnt_pre",   OpCount_o, 0);
        @(negedge Clk_i);               // handshake at edge N+3
        check("add_hs_valid",  RspValid_o, 0);
        check("add_hs_ready",  ReqReady_o, 1);
        check("add_op_count",  OpCount_o, 1);

        // AND then OR back to back.
        run_op(2'd2, 8'hF0, 8'h3C, d1, o1, acc1);
        run_op(2'd3, 8'hF0, 8'h3C, d2, o2, acc2);
        check("and_data", d1, 8'h30);
        check("and_ovf",  o1, 0);
        check("or_data",  d2, 8'hFC);
        check("or_ovf",   o2, 0);
        check("b2b_gap_ge4", (acc2 - acc1) >= 4, 1);
        @(negedge Clk_i);
        check("b2b_op_count", OpCount_o, 3);

        // SUB 5-7 with the consumer stalled; a new request is held on the
        // inputs meanwhile and must not be sampled.
        ReqValid_i = 1'b1;
        ReqOpc_i   = 2'd1;
        ReqA_i     = 8'd5;
        ReqB_i     = 8'd7;
        RspReady_i = 1'b0;
        @(negedge Clk_i);               // accepted at the edge just passed
        ReqOpc_i = 2'd3;
        ReqA_i   = 8'hFF;
        ReqB_i   = 8'hAA;
        n = 0;
        while (!RspValid_o && n < 10) begin
            @(negedge Clk_i);
            n++;
        end
        check("sub_valid_seen", RspValid_o, 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", RspValid_o, 1);
            check("stall_data",  RspData_o, 8'hFE);
            check("stall_ovf",   RspOverFlow_o, 1);
            check("stall_ready", ReqReady_o, 0);
            check("stall_alu_a", AluA_o, 5);
            check("stall_alu_opc", AluOpc_o, 1);
            @(negedge Clk_i);
        end
        check("stall_op_count", OpCount_o, 3);
        RspReady_i = 1'b1;
        @(negedge Clk_i);               // single handshake
        ReqValid_i = 1'b0;
        check("rel_valid",     RspValid_o, 0);
        check("rel_ready",     ReqReady_o, 1);
        check("rel_op_count",  OpCount_o, 4);
        @(negedge Clk_i);
        check("rel_no_accept", ReqReady_o, 1);
        check("rel_op_count2", OpCount_o, 4);

        // Reset pulsed during CAPT.
        ReqValid_i = 1'b1;
        ReqOpc_i   = 2'd0;
        ReqA_i     = 8'd17;
        ReqB_i     = 8'd9;
        @(negedge Clk_i);               // now in EXEC
        ReqValid_i = 1'b0;
        @(negedge Clk_i);               // now in CAPT
        check("capt_valid", RspValid_o, 0);
        Reset_i = 1'b1;
        #2;
        Reset_i = 1'b0;
        #1;
        check("rr_ready",     ReqReady_o, 1);
        check("rr_valid",     RspValid_o, 0);
        check("rr_alu_opc",   AluOpc_o, 0);
        check("rr_alu_a",     AluA_o, 0);
        check("rr_alu_b",     AluB_o, 0);
        check("rr_rsp_data",  RspData_o, 0);
        check("rr_rsp_ovf",   RspOverFlow_o, 0);
        check("rr_op_count",  OpCount_o, 0);
        check("rr_ovf_count", OvfCount_o, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk_i);
            check("rr_no_rsp", RspValid_o, 0);
            check("rr_idle",   ReqReady_o, 1);
        end

        // OpCount_o wrap from 0xFFFF.
        @(negedge Clk_i);
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        #1;
        check("wrap_preload", OpCount_o, 16'hFFFF);
        run_op(2'd2, 8'hAA, 8'h0F, d1, o1, acc1);
        @(negedge Clk_i);
        check("wrap_data",  d1, 8'h0A);
        check("wrap_count", OpCount_o, 16'h0000);

        // 300 overflowing ADDs.
        for (int i = 0; i < 300; i++) begin
            run_op(2'd0, 8'd255, 8'd2, d1, o1, acc1);
        end
        @(negedge Clk_i);
        check("ovf_last_data", d1, 8'd1);
        check("ovf_last_flag", o1, 1);
        check("ovf_op_count",  OpCount_o, 300);
`ifdef ALU_CTRL_OVF_CNT_EN
        check("ovf_count", OvfCount_o, 255);
`else
        check("ovf_count", OvfCount_o, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter: Width, default 8, operand/result width in bits.
REQ-002 Clk_i  input  1  single clock, all state updates on rising edge.
REQ-003 Reset_i  input  1  reset, asynchronous, active-high.
REQ-004 ReqValid_i  input  1  request valid.
REQ-005 ReqReady_o  output  1  request accepted when ReqValid_i & ReqReady_o at rising edge.
REQ-006 ReqOpc_i  input  2  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR.
REQ-007 ReqA_i, ReqB_i  input  Width each  operands A and B.
REQ-008 AluOpc_o  output  2  opcode driven to the ALU.
REQ-009 AluA_o, AluB_o  output  Width each  operands driven to the ALU.
REQ-010 AluDout_i  input  Width  ALU result, valid one cycle after operands are sampled.
REQ-011 AluOverFlow_i  input  1  ALU overflow flag, same timing as AluDout_i.
REQ-012 RspValid_o  output  1  response valid.
REQ-013 RspReady_i  input  1  response consumed when RspValid_o & RspReady_i at rising edge.
REQ-014 RspData_o  output  Width  captured ALU result.
REQ-015 RspOverFlow_o  output  1  captured ALU overflow.
REQ-016 OpCount_o  output  16  completed-response counter.
REQ-017 OvfCount_o  output  8  overflow-response counter (see Configuration).

Function
REQ-018 FSM states: IDLE, EXEC, CAPT, RESP.
REQ-019 IDLE: ReqReady_o=1; on accept, latch ReqOpc_i/ReqA_i/ReqB_i into operand registers and go to EXEC.
REQ-020 EXEC: lasts exactly one cycle, ALU samples operands at its end; go to CAPT.
REQ-021 CAPT: lasts exactly one cycle; at its end, register AluDout_i into RspData_o and AluOverFlow_i into RspOverFlow_o; go to RESP.
REQ-022 RESP: RspValid_o=1; RspData_o/RspOverFlow_o held stable until the handshake; on handshake go to IDLE.
REQ-023 ReqReady_o is 0 in EXEC, CAPT, RESP; there is no same-cycle bypass from RESP to a new accept.
REQ-024 Latency: accept at edge N -> RspValid_o=1 from edge N+3; minimum issue interval 4 cycles.
REQ-025 AluOpc_o/AluA_o/AluB_o are driven directly from the operand registers and hold the last accepted request in every state.
REQ-026 OpCount_o increments by 1 on each response handshake and wraps 0xFFFF -> 0x0000.
REQ-027 No width extension is performed on results: RspData_o is exactly Width bits as returned by the ALU.
REQ-028 ReqValid_i outside IDLE is ignored; request inputs are not sampled until the next IDLE cycle.

Reset
REQ-029 Reset_i asserted, in any state including mid-operation: FSM -> IDLE immediately, no response is produced for an in-flight request.
REQ-030 Reset values: operand registers 0, AluOpc_o 0, RspValid_o 0, RspData_o 0, RspOverFlow_o 0, OpCount_o 0, OvfCount_o 0; ReqReady_o 1 once reset is deasserted.

Configuration
REQ-031 Macro ALU_CTRL_OVF_CNT_EN defined: OvfCount_o increments on each response handshake with RspOverFlow_o=1, saturating at 255.
REQ-032 Macro ALU_CTRL_OVF_CNT_EN undefined: counter logic is omitted and OvfCount_o is tied to 0.

Verification
REQ-033 ADD A=200 B=100, ALU model returns 44/ovf=1, RspReady_i=1 -> RspValid_o at N+3, RspData_o=44, RspOverFlow_o=1, OpCount_o=1.
REQ-034 AND 0xF0,0x3C then OR 0xF0,0x3C back-to-back -> responses 0x30 then 0xFC, second accept no earlier than 4 cycles after the first.
REQ-035 SUB 5-7 with RspReady_i=0 for 5 cycles -> RspValid_o held, RspData_o=0xFE stable, ReqReady_o=0 throughout, single handshake on release.
REQ-036 Reset_i pulsed during CAPT -> next cycle in IDLE, RspValid_o never asserts for that request, all outputs at reset values.
REQ-037 OpCount_o preloaded to 0xFFFF via 65535 ops (or force) plus one op -> OpCount_o=0x0000.
REQ-038 With ALU_CTRL_OVF_CNT_EN, 300 overflowing ADDs -> OvfCount_o=255; without the macro -> OvfCount_o=0.
